// File: rtl/conv_frame_encoder.sv
// rtl/conv_frame_encoder.sv - rate 1/2 K=3 (7,5) convolutional frame encoder with input bit FIFO
module conv_frame_encoder #(
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       ready_o,
  input  logic       stall_i,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic [7:0] frame_ct_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  logic [FIFO_DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic [1:0]  state;
  logic [1:0]  sr;
  logic [15:0] bit_cnt;
  logic        tail_cnt;

  logic fifo_empty;
  logic advance;
  logic push;
  logic pop;
  logic u;
  logic [1:0] sym;

  // FIFO handshake and the encoder datapath for the bit about to be registered
  always_comb begin
    fifo_empty = (count == '0);
    ready_o    = (count != FIFO_FULL);
    advance    = !(valid_o && stall_i);
    push       = enable_i && ready_o;
    // Pops only see entries already stored, so a bit written this edge waits one cycle
    pop        = advance && !fifo_empty && (state != ST_TAIL);
    u          = (state == ST_TAIL) ? 1'b0 : mem[rd_ptr];
    sym        = {u ^ sr[1] ^ sr[0], u ^ sr[0]};
  end

  // Input bit FIFO: simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= d_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: data symbols, two flushing tail symbols, frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      sr            <= 2'b00;
      bit_cnt       <= '0;
      tail_cnt      <= 1'b0;
      valid_o       <= 1'b0;
      d_out         <= 2'b00;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      frame_ct_o    <= 8'd0;
    end else if (advance) begin
      case (state)
        ST_IDLE, ST_DATA: begin
          if (!fifo_empty) begin
            d_out         <= sym;
            valid_o       <= 1'b1;
            frame_start_o <= (state == ST_IDLE);
            frame_end_o   <= 1'b0;
            sr            <= {u, sr[1]};
            bit_cnt       <= bit_cnt + 16'd1;
            if (bit_cnt == LAST_IDX) begin
              state    <= ST_TAIL;
              tail_cnt <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            // Bubble: nothing to encode, keep state, bit count and history
            valid_o       <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
          end
        end
        ST_TAIL: begin
          d_out         <= sym;
          valid_o       <= 1'b1;
          frame_start_o <= 1'b0;
          if (tail_cnt) begin
            frame_end_o <= 1'b1;
            frame_ct_o  <= frame_ct_o + 8'd1;
            sr          <= 2'b00;
            bit_cnt     <= '0;
            tail_cnt    <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            frame_end_o <= 1'b0;
            sr          <= {1'b0, sr[1]};
            tail_cnt    <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// tb/tb_conv_frame_encoder.sv - directed self-checking bench for conv_frame_encoder
module tb_conv_frame_encoder;

  logic       clk;
  logic       rst;
  logic       enable_i;
  logic       d_in;
  logic       stall_i;
  logic       ready_o;
  logic       valid_o;
  logic [1:0] d_out;
  logic       frame_start_o;
  logic       frame_end_o;
  logic [7:0] frame_ct_o;

  logic       enable_1;
  logic       d_in_1;
  logic       stall_1;
  logic       ready_1;
  logic       valid_1;
  logic [1:0] d_out_1;
  logic       start_1;
  logic       end_1;
  logic [7:0] ct_1;

  int checks;
  int errors;

  // {frame_start, frame_end, d_out} of each consumed symbol of the FRAME_LEN=4 instance
  logic [3:0] sym_q[$];
  logic [3:0] exp_sym [0:6];

  conv_frame_encoder #(.FRAME_LEN(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in), .ready_o(ready_o),
    .stall_i(stall_i), .valid_o(valid_o), .d_out(d_out),
    .frame_start_o(frame_start_o), .frame_end_o(frame_end_o), .frame_ct_o(frame_ct_o)
  );

  conv_frame_encoder #(.FRAME_LEN(1), .FIFO_DEPTH(4)) dut_len1 (
    .clk(clk), .rst(rst), .enable_i(enable_1), .d_in(d_in_1), .ready_o(ready_1),
    .stall_i(stall_1), .valid_o(valid_1), .d_out(d_out_1),
    .frame_start_o(start_1), .frame_end_o(end_1), .frame_ct_o(ct_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && valid_o && !stall_i) sym_q.push_back({frame_start_o, frame_end_o, d_out});
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (d_out !== 2'b00) begin errors++; $display("FAIL reset_d_out: got %b expected 00", d_out); end
    checks++; if ({frame_start_o, frame_end_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {frame_start_o, frame_end_o}); end
    checks++; if (frame_ct_o !== 8'd0) begin errors++; $display("FAIL reset_frame_ct: got %0d expected 0", frame_ct_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid%0d: got %b expected 0", i, valid_o); end
    end
  endtask

  task test_basic;
    sym_q.delete();
    enable_i = 1'b1; d_in = 1'b1; step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL latency_early: got valid %b expected 0", valid_o); end
    d_in = 1'b0; step();
    checks++; if ({valid_o, frame_start_o} !== 2'b11) begin errors++; $display("FAIL latency_first: got valid/start %b expected 11", {valid_o, frame_start_o}); end
    d_in = 1'b1; step();
    d_in = 1'b1; step();
    enable_i = 1'b0;
    repeat (6) step();
    checks++; if (sym_q.size() !== 6) begin errors++; $display("FAIL basic_count: got %0d symbols expected 6", sym_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= sym_q.size()) begin errors++; $display("FAIL basic_sym%0d: missing expected %b", i, exp_sym[i]); end
      else if (sym_q[i] !== exp_sym[i]) begin errors++; $display("FAIL basic_sym%0d: got %b expected %b", i, sym_q[i], exp_sym[i]); end
    end
    checks++; if (frame_ct_o !== 8'd1) begin errors++; $display("FAIL basic_frame_ct: got %0d expected 1", frame_ct_o); end
  endtask

  task test_bubble;
    sym_q.delete();
    enable_i = 1'b1; d_in = 1'b1; step();
    d_in = 1'b0; step();
    enable_i = 1'b0; step();
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bubble_gap0: got valid %b expected 0", valid_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bubble_gap1: got valid %b expected 0", valid_o); end
    enable_i = 1'b1; d_in = 1'b1; step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bubble_gap2: got valid %b expected 0", valid_o); end
    d_in = 1'b1; step();
    enable_i = 1'b0;
    repeat (8) step();
    checks++; if (sym_q.size() !== 6) begin errors++; $display("FAIL bubble_count: got %0d symbols expected 6", sym_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= sym_q.size()) begin errors++; $display("FAIL bubble_sym%0d: missing expected %b", i, exp_sym[i]); end
      else if (sym_q[i] !== exp_sym[i]) begin errors++; $display("FAIL bubble_sym%0d: got %b expected %b", i, sym_q[i], exp_sym[i]); end
    end
    checks++; if (frame_ct_o !== 8'd2) begin errors++; $display("FAIL bubble_frame_ct: got %0d expected 2", frame_ct_o); end
  endtask

  task test_backpressure;
    logic [5:0] bits;
    bits = 6'b101101;
    sym_q.delete();
    stall_i = 1'b1;
    enable_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_in = bits[5 - i];
      step();
      if (i == 1) begin
        checks++; if ({valid_o, d_out} !== 3'b111) begin errors++; $display("FAIL bp_first: got valid/d_out %b expected 111", {valid_o, d_out}); end
      end
      if (i >= 4) begin
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0", i, ready_o); end
      end
    end
    enable_i = 1'b0;
    step();
    checks++; if ({valid_o, d_out, frame_start_o} !== 4'b1111) begin errors++; $display("FAIL bp_hold: got valid/d_out/start %b expected 1111", {valid_o, d_out, frame_start_o}); end
    stall_i = 1'b0;
    repeat (12) step();
    exp_sym[6] = 4'b1000;
    checks++; if (sym_q.size() !== 7) begin errors++; $display("FAIL bp_count: got %0d symbols expected 7", sym_q.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= sym_q.size()) begin errors++; $display("FAIL bp_sym%0d: missing expected %b", i, exp_sym[i]); end
      else if (sym_q[i] !== exp_sym[i]) begin errors++; $display("FAIL bp_sym%0d: got %b expected %b", i, sym_q[i], exp_sym[i]); end
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid %b expected 0", valid_o); end
  endtask

  task test_reset_mid_frame;
    enable_i = 1'b1; d_in = 1'b1; step();
    d_in = 1'b0; step();
    d_in = 1'b1; step();
    rst = 1'b0;
    enable_i = 1'b0;
    #1;
    checks++; if ({valid_o, d_out, frame_start_o, frame_end_o} !== 5'b0) begin errors++; $display("FAIL midrst_outputs: got %b expected 00000", {valid_o, d_out, frame_start_o, frame_end_o}); end
    checks++; if (frame_ct_o !== 8'd0) begin errors++; $display("FAIL midrst_frame_ct: got %0d expected 0", frame_ct_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready_o); end
    step();
    step();
    rst = 1'b1;
    sym_q.delete();
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_no_tail: got valid %b expected 0", valid_o); end
    enable_i = 1'b1; d_in = 1'b1; step();
    d_in = 1'b0; step();
    d_in = 1'b1; step();
    d_in = 1'b1; step();
    enable_i = 1'b0;
    repeat (6) step();
    checks++; if (sym_q.size() !== 6) begin errors++; $display("FAIL midrst_count: got %0d symbols expected 6", sym_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= sym_q.size()) begin errors++; $display("FAIL midrst_sym%0d: missing expected %b", i, exp_sym[i]); end
      else if (sym_q[i] !== exp_sym[i]) begin errors++; $display("FAIL midrst_sym%0d: got %b expected %b", i, sym_q[i], exp_sym[i]); end
    end
    checks++; if (frame_ct_o !== 8'd1) begin errors++; $display("FAIL midrst_frame_ct_after: got %0d expected 1", frame_ct_o); end
  endtask

  task test_wrap;
    int ends;
    int syms;
    int both;
    logic [3:0] first3 [0:2];
    logic [3:0] exp3 [0:2];
    exp3[0] = 4'b1011;
    exp3[1] = 4'b0010;
    exp3[2] = 4'b0111;
    ends = 0;
    syms = 0;
    both = 0;
    enable_1 = 1'b1;
    d_in_1 = 1'b1;
    for (int cyc = 0; cyc < 1200 && ends < 256; cyc++) begin
      step();
      if (valid_1) begin
        if (syms < 3) first3[syms] = {start_1, end_1, d_out_1};
        syms++;
        if (start_1 && end_1) both++;
        if (end_1) begin
          ends++;
          if (ends == 255) begin
            checks++; if (ct_1 !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", ct_1); end
          end
          if (ends == 256) begin
            checks++; if (ct_1 !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", ct_1); end
          end
        end
      end
    end
    enable_1 = 1'b0;
    checks++; if (ends !== 256) begin errors++; $display("FAIL wrap_timeout: got %0d frame ends expected 256", ends); end
    checks++; if (both !== 0) begin errors++; $display("FAIL len1_flags_split: got %0d symbols with both flags expected 0", both); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (first3[i] !== exp3[i]) begin errors++; $display("FAIL len1_sym%0d: got %b expected %b", i, first3[i], exp3[i]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    enable_i = 1'b0; d_in = 1'b0; stall_i = 1'b0;
    enable_1 = 1'b0; d_in_1 = 1'b0; stall_1 = 1'b0;
    exp_sym[0] = 4'b1011;
    exp_sym[1] = 4'b0010;
    exp_sym[2] = 4'b0000;
    exp_sym[3] = 4'b0001;
    exp_sym[4] = 4'b0001;
    exp_sym[5] = 4'b0111;
    exp_sym[6] = 4'b0000;
    test_reset();
    test_basic();
    test_bubble();
    test_backpressure();
    test_reset_mid_frame();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
